// File: rtl/noc_pkg.sv
// noc_pkg: shared flit type, widths and sticky error bit indices for the endpoint bridge.
package noc_pkg;
    localparam int FLIT_WIDTH    = 256;
    localparam int DEST_WIDTH    = 4;
    localparam int ERR_TX_CREDIT = 0;
    localparam int ERR_RX_OVF    = 1;
    localparam int ERR_TX_DEST   = 2;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } flit_t;
endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: synchronous FIFO with registered occupancy count and wrap-bit pointers.
module noc_flit_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             do_push, do_pop;

    assign empty_o    = cnt_q == '0;
    assign full_o     = cnt_q == (AW+1)'(FIFO_DEPTH);
    assign do_pop     = pop_i & ~empty_o;
    // A pop on a full FIFO frees the slot the same edge, so the push is still taken.
    assign do_push    = push_i & (~full_o | do_pop);
    assign overflow_o = push_i & full_o & ~do_pop;
    assign rdata_o    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d  = wr_q + (AW+1)'(do_push);
        rd_d  = rd_q + (AW+1)'(do_pop);
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/noc_endpoint_bridge.sv
// noc_endpoint_bridge: valid/ready <-> credit-based router local port adapter with
// packet destination checking and sticky credit/buffer error flags.
module noc_endpoint_bridge
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH = noc_pkg::FLIT_WIDTH,
    parameter int DEST_WIDTH = noc_pkg::DEST_WIDTH,
    parameter int TX_CREDITS = 2,
    parameter int RX_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [FLIT_WIDTH-1:0] tx_data,
    input  logic [DEST_WIDTH-1:0] tx_dest,
    input  logic                  tx_is_tail,
    output logic                  send_out,
    output logic [FLIT_WIDTH-1:0] data_out,
    output logic [DEST_WIDTH-1:0] dest_out,
    output logic                  is_tail_out,
    input  logic                  credit_in,
    input  logic                  send_in,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    output logic                  credit_out,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic [FLIT_WIDTH-1:0] rx_data,
    output logic [DEST_WIDTH-1:0] rx_dest,
    output logic                  rx_is_tail,
    output logic [2:0]            err
);
    localparam int CW = $clog2(TX_CREDITS + 1);

    logic [CW-1:0]         credit_q, credit_d;
    logic                  send_q, in_pkt_q, in_pkt_d, credit_out_q;
    logic [DEST_WIDTH-1:0] pkt_dest_q, pkt_dest_d;
    logic [2:0]            err_q, err_d;
    flit_t                 tx_q, tx_d, rx_flit;
    logic                  fire, cred_ovf, dest_err, rx_empty, rx_full, rx_ovf, pop;

    assign tx_ready = credit_q != '0;
    assign fire     = tx_valid & tx_ready;
    // A spare credit with the counter already full means the router returned more than it owns.
    assign cred_ovf = credit_in & ~fire & (credit_q == CW'(TX_CREDITS));
    assign dest_err = fire & in_pkt_q & (tx_dest != pkt_dest_q);
    assign pop      = rx_valid & rx_ready;

    always_comb begin
        credit_d   = cred_ovf ? credit_q : credit_q + CW'(credit_in) - CW'(fire);
        tx_d       = fire ? '{data: tx_data, dest: tx_dest, is_tail: tx_is_tail} : tx_q;
        in_pkt_d   = fire ? ~tx_is_tail : in_pkt_q;
        pkt_dest_d = (fire & ~in_pkt_q) ? tx_dest : pkt_dest_q;
        err_d      = err_q;
        err_d[ERR_TX_CREDIT] = err_q[ERR_TX_CREDIT] | cred_ovf;
        err_d[ERR_RX_OVF]    = err_q[ERR_RX_OVF] | rx_ovf;
        err_d[ERR_TX_DEST]   = err_q[ERR_TX_DEST] | dest_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q     <= CW'(TX_CREDITS);
            send_q       <= 1'b0;
            tx_q         <= '0;
            in_pkt_q     <= 1'b0;
            pkt_dest_q   <= '0;
            err_q        <= '0;
            credit_out_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            send_q       <= fire;
            tx_q         <= tx_d;
            in_pkt_q     <= in_pkt_d;
            pkt_dest_q   <= pkt_dest_d;
            err_q        <= err_d;
            credit_out_q <= pop;
        end
    end

    noc_flit_fifo #(
        .FIFO_DEPTH(RX_DEPTH),
        .WIDTH     ($bits(flit_t))
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (send_in),
        .pop_i     (pop),
        .wdata_i   ({data_in, dest_in, is_tail_in}),
        .rdata_o   (rx_flit),
        .full_o    (rx_full),
        .empty_o   (rx_empty),
        .overflow_o(rx_ovf)
    );

    assign send_out    = send_q;
    assign data_out    = tx_q.data;
    assign dest_out    = tx_q.dest;
    assign is_tail_out = tx_q.is_tail;
    assign credit_out  = credit_out_q;
    assign rx_valid    = ~rx_empty;
    assign rx_data     = rx_flit.data;
    assign rx_dest     = rx_flit.dest;
    assign rx_is_tail  = rx_flit.is_tail;
    assign err         = err_q;

    logic unused_full;
    assign unused_full = rx_full;
endmodule

// File: tb/tb_noc_endpoint_bridge.sv
// tb_noc_endpoint_bridge: directed vectors with hand-computed expectations for TX credits,
// RX buffering/credit return, and sticky error flags.
module tb_noc_endpoint_bridge;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tx_valid = 1'b0, tx_ready, tx_is_tail = 1'b0;
    logic [255:0] tx_data = '0, data_out, data_in = '0, rx_data;
    logic [3:0]   tx_dest = '0, dest_out, dest_in = '0, rx_dest;
    logic         send_out, is_tail_out, credit_in = 1'b0;
    logic         send_in = 1'b0, is_tail_in = 1'b0, credit_out;
    logic         rx_valid, rx_ready = 1'b0, rx_is_tail;
    logic [2:0]   err;
    int           n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    noc_endpoint_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_dest(tx_dest),
        .tx_is_tail(tx_is_tail), .send_out(send_out), .data_out(data_out), .dest_out(dest_out),
        .is_tail_out(is_tail_out), .credit_in(credit_in), .send_in(send_in), .data_in(data_in),
        .dest_in(dest_in), .is_tail_in(is_tail_in), .credit_out(credit_out), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_dest(rx_dest), .rx_is_tail(rx_is_tail),
        .err(err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_rx(input logic [255:0] d);
        send_in = 1'b1;
        data_in = d;
        dest_in = d[3:0];
        is_tail_in = d[0];
        tick();
        send_in = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_tx_ready", tx_ready, 1);
        check("rst_send_out", send_out, 0);
        check("rst_credit_out", credit_out, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_err", err, 0);
        check("rst_data_out", data_out, 0);

        // 1: three flits, two credits
        tx_valid = 1'b1; tx_dest = 4'd1; tx_data = 256'hA1;
        tick();
        check("t1_send1", send_out, 1);
        check("t1_data1", data_out, 256'hA1);
        check("t1_ready1", tx_ready, 1);
        tx_data = 256'hA2;
        tick();
        check("t1_send2", send_out, 1);
        check("t1_data2", data_out, 256'hA2);
        check("t1_ready2", tx_ready, 0);
        tx_data = 256'hA3; tx_is_tail = 1'b1;
        tick();
        check("t1_nosend", send_out, 0);
        check("t1_hold", data_out, 256'hA2);
        check("t1_stall", tx_ready, 0);
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("t1_ready_cred", tx_ready, 1);
        check("t1_nosend2", send_out, 0);
        tick();
        check("t1_send3", send_out, 1);
        check("t1_data3", data_out, 256'hA3);
        check("t1_tail3", is_tail_out, 1);
        check("t1_ready3", tx_ready, 0);
        tx_valid = 1'b0; tx_is_tail = 1'b0;
        credit_in = 1'b1;
        tick(); tick();
        credit_in = 1'b0;
        check("t1_err", err, 0);

        // 2: back-to-back stream with a credit returned every cycle
        tx_valid = 1'b1; credit_in = 1'b1; tx_dest = 4'd2;
        for (int i = 0; i < 4; i++) begin
            tx_data = 256'hB0 + 256'(i);
            tx_is_tail = (i == 3);
            tick();
            check("t2_send", send_out, 1);
            check("t2_data", data_out, 256'hB0 + 256'(i));
            check("t2_ready", tx_ready, 1);
        end
        tx_valid = 1'b0; credit_in = 1'b0; tx_is_tail = 1'b0;
        tick();
        check("t2_err", err, 0);

        // 3: surplus credit while full saturates and flags err[0]
        credit_in = 1'b1;
        tick();
        credit_in = 1'b0;
        check("t3_err", err, 3'b001);
        tx_valid = 1'b1; tx_is_tail = 1'b1; tx_dest = 4'd3;
        tick(); tick();
        tx_valid = 1'b0; tx_is_tail = 1'b0;
        check("t3_count_sat", tx_ready, 0);
        credit_in = 1'b1;
        tick(); tick();
        credit_in = 1'b0;

        // 4: fill RX FIFO, then overflow
        do_reset();
        push_rx(256'hC1);
        check("t4_latency", rx_valid, 1);
        check("t4_head", rx_data, 256'hC1);
        push_rx(256'hC2); push_rx(256'hC3); push_rx(256'hC4);
        check("t4_nocredit", credit_out, 0);
        check("t4_err_ok", err, 0);
        push_rx(256'hC5);
        check("t4_ovf", err, 3'b010);
        check("t4_head_kept", rx_data, 256'hC1);

        // 5: simultaneous push and pop on a full FIFO
        do_reset();
        push_rx(256'hD1); push_rx(256'hD2); push_rx(256'hD3); push_rx(256'hD4);
        rx_ready = 1'b1;
        push_rx(256'hD5);
        rx_ready = 1'b0;
        check("t5_noerr", err, 0);
        check("t5_credit", credit_out, 1);
        check("t5_head", rx_data, 256'hD2);
        tick();
        check("t5_one_pulse", credit_out, 0);
        push_rx(256'hDF);
        check("t5_still_full", err, 3'b010);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_order", rx_data, (i == 3) ? 256'hD5 : 256'hD2 + 256'(i));
            tick();
            check("t5_pulse", credit_out, 1);
        end
        rx_ready = 1'b0;
        check("t5_empty", rx_valid, 0);

        // 6: destination change mid-packet
        do_reset();
        tx_valid = 1'b1; credit_in = 1'b1;
        tx_dest = 4'd5; tx_data = 256'hE1;
        tick();
        tx_data = 256'hE2;
        tick();
        check("t6_noerr", err, 0);
        tx_dest = 4'd6; tx_data = 256'hE3; tx_is_tail = 1'b1;
        tick();
        check("t6_sent", send_out, 1);
        check("t6_dest", dest_out, 4'd6);
        check("t6_err", err, 3'b100);
        tx_is_tail = 1'b0; tx_data = 256'hE4;
        tick();
        tx_is_tail = 1'b1; tx_data = 256'hE5;
        tick();
        tx_valid = 1'b0; credit_in = 1'b0; tx_is_tail = 1'b0;
        check("t6_err_sticky", err, 3'b100);
        check("t6_last", data_out, 256'hE5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
